// File: rtl/led_pattern_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_pattern_queue: FIFO of 16-bit LED patterns, each shown for a dwell   |
// | time and swapped only on a driver frame boundary.                        |
// | Optional loop playback: define LED_PATTERN_LOOP_EN (adds i_Loop).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_pattern_queue #(
    parameter int          DEPTH        = 4,
    parameter int          DWELL_CYCLES = 1000000,
    parameter logic [15:0] INIT_PATTERN = 16'h0000
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    input  logic                     i_WrValid,
    input  logic [15:0]              i_WrData,
    output logic                     o_WrReady,
    input  logic                     i_Clear,
    input  logic                     i_FrameDone,
`ifdef LED_PATTERN_LOOP_EN
    input  logic                     i_Loop,
`endif
    output logic [15:0]              o_Data16,
    output logic                     o_Update,
    output logic [$clog2(DEPTH):0]   o_Level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [LW-1:0] C_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] C_LAST = CW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        DWELL      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     data_q, data_d;
    logic            update_q, update_d;
    logic            fd_q;
    logic [15:0]     mem_q [DEPTH];

    logic            w_loop;
    logic            w_fd_edge;
    logic            w_push;
    logic            w_pop;
    logic            w_wb;
    logic            w_wr_en;
    logic [15:0]     w_wr_data;

`ifdef LED_PATTERN_LOOP_EN
    assign w_loop = i_Loop;
`else
    assign w_loop = 1'b0;
`endif

    always_comb begin
        w_fd_edge = i_FrameDone & ~fd_q;
        // Full refuses a push even when a pop lands in the same cycle.
        o_WrReady = (level_q != C_FULL) && !i_Clear && !w_loop;
        w_push    = i_WrValid && o_WrReady;
        w_pop     = (state_q == WAIT_FRAME) && w_fd_edge && !i_Clear && (level_q != '0);
        // Loop playback recycles the popped head into the tail slot.
        w_wb      = w_pop && w_loop;
        w_wr_en   = w_push || w_wb;
        w_wr_data = w_push ? i_WrData : mem_q[rd_ptr_q];
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        data_d   = w_pop ? mem_q[rd_ptr_q] : data_q;
        update_d = w_pop;

        if (i_Clear) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(w_wr_en);
            rd_ptr_d = rd_ptr_q + AW'(w_pop);
            level_d  = level_q + LW'(w_push) + LW'(w_wb) - LW'(w_pop);
            case (state_q)
                IDLE: begin
                    if (level_q != '0) state_d = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (w_pop) begin
                        cnt_d   = '0;
                        state_d = DWELL;
                    end
                end
                DWELL: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        state_d = (level_q != '0) ? WAIT_FRAME : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            data_q   <= INIT_PATTERN;
            update_q <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            update_q <= update_d;
            fd_q     <= i_FrameDone;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (w_wr_en) mem_q[wr_ptr_q] <= w_wr_data;
    end

    assign o_Data16 = data_q;
    assign o_Update = update_q;
    assign o_Level  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_pattern_queue: randomized scoreboard bench for led_pattern_queue. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_led_pattern_queue;

    localparam int          DEPTH = 4;
    localparam int          DWELL = 4;
    localparam logic [15:0] INIT  = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        clear = 1'b0;
    logic        fd = 1'b0;
    logic        loop = 1'b0;
    logic        wr_ready;
    logic [15:0] data16;
    logic        update;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_queue #(
        .DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .INIT_PATTERN(INIT)
    ) dut (
        .i_CLK(clk), .i_RESET(rst_n), .i_WrValid(wr_valid), .i_WrData(wr_data),
        .o_WrReady(wr_ready), .i_Clear(clear), .i_FrameDone(fd),
`ifdef LED_PATTERN_LOOP_EN
        .i_Loop(loop),
`endif
        .o_Data16(data16), .o_Update(update), .o_Level(level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of patterns plus the earliest edge at which
    // the next frame edge may show a new one.
    typedef struct { int lvl; logic [15:0] data; logic upd; } exp_t;
    exp_t        exp_q[$];
    logic [15:0] exp_upd[$];
    logic [15:0] mq[$];
    logic [15:0] disp = INIT;
    logic        fd_prev = 1'b0;
    int          n = 0;
    int          dwell_end = 0;
    int          ready_at = 0;

    always @(posedge clk) begin
        exp_t        e;
        logic        fe, do_pop, do_push, upd;
        int          pre;
        logic [15:0] w;
        upd = 1'b0;
        if (!rst_n) begin
            mq.delete();
            disp = INIT; fd_prev = 1'b0; dwell_end = 0; ready_at = 0;
        end else begin
            fe      = fd && !fd_prev;
            fd_prev = fd;
            pre     = mq.size();
            do_pop  = fe && pre > 0 && n >= ready_at && !clear;
            do_push = wr_valid && pre < DEPTH && !clear && !loop;
            if (clear) begin
                mq.delete();
                dwell_end = 0;
            end else begin
                if (do_pop) begin
                    w = mq.pop_front();
                    disp = w; upd = 1'b1;
                    exp_upd.push_back(w);
                    dwell_end = n + DWELL + 1;
                    ready_at  = dwell_end;
                    if (loop) mq.push_back(w);
                end
                if (do_push) begin
                    if (pre == 0) ready_at = (dwell_end > n + 2) ? dwell_end : n + 2;
                    mq.push_back(wr_data);
                end
            end
        end
        e.lvl = mq.size(); e.data = disp; e.upd = upd;
        exp_q.push_back(e);
        n++;
    end

    // Monitor: compares the DUT against the model shortly after each edge.
    always @(posedge clk) begin
        exp_t        e;
        logic [15:0] w;
        #2;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: no expected entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("level",  32'(level),  32'(e.lvl));
            chk("data16", 32'(data16), 32'(e.data));
            chk("update", 32'(update), 32'(e.upd));
            chk("wr_ready", 32'(wr_ready), 32'((e.lvl < DEPTH) && !clear && !loop));
        end
        if (update) begin
            if (exp_upd.size() == 0) begin
                checks++; errors++;
                $display("FAIL upd_unexpected: got %0h expected none", data16);
            end else begin
                w = exp_upd.pop_front();
                chk("upd_data", 32'(data16), 32'(w));
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic f, input logic c);
        @(negedge clk);
        wr_valid = v; wr_data = d; fd = f; clear = c;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic frames(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 16'h0, (i % 3) == 0, 1'b0);
    endtask

    initial begin
        repeat (10) step(1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("rst_data",  32'(data16),   32'(INIT));
        chk("rst_level", 32'(level),    32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_upd",   32'(update),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b1, 1'b0);
        idle(4);

        step(1'b1, 16'h9D1F, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        frames(30);

        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        idle(3);
        frames(24);

        step(1'b1, 16'hC001, 1'b0, 1'b0);
        step(1'b1, 16'hC002, 1'b0, 1'b0);
        step(1'b1, 16'hC003, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 16'hBEEF, 1'b0, 1'b1);
        frames(18);

        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 63) == 0);

        step(1'b0, 16'h0, 1'b0, 1'b1);
        idle(6);
        step(1'b1, 16'h1111, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        idle(1);
        #1;
        chk("dwell_level", 32'(level),  32'd2);
        chk("dwell_data",  32'(data16), 32'h1111);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_data",  32'(data16),   32'(INIT));
        chk("arst_level", 32'(level),    32'd0);
        chk("arst_upd",   32'(update),   32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frames(12);
        @(posedge clk);
        #4;
        chk("upd_leftover", 32'(exp_upd.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
